// File: rtl/shift_pkg.sv
// Shared shift-function encoding used by the serial transmitter and receiver.
//   funct_t      : 2-bit shift operation code (NA, LOAD, LEFT, RIGHT)
//   is_shift_dir : true for the two encodings that describe a serial direction
package shift_pkg;

  typedef enum logic [1:0] {
    NA    = 2'b00,
    LOAD  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } funct_t;

  // Only LEFT (MSB first) and RIGHT (LSB first) define a serial frame.
  function automatic logic is_shift_dir(input funct_t f);
    return (f == LEFT) || (f == RIGHT);
  endfunction

endpackage

// File: rtl/word_out_buffer.sv
// One-entry valid/ready holding register with overrun flag.
//   clk, rst   : clock, async active-high reset
//   load_i     : a new word is offered this cycle
//   data_i     : the offered word
//   ready_i    : consumer accepts word_o this cycle
//   word_o     : held word (keeps its stale value after a transfer)
//   valid_o    : word_o holds an unconsumed word
//   overrun_o  : one-cycle pulse when an offered word is dropped
module word_out_buffer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  // Next-state: a load is accepted if the slot is empty or drains this cycle.
  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_i) begin
      if (!valid_q || ready_i) begin
        word_d  = data_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign word_o    = word_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver for an MSB-first (LEFT) or LSB-first (RIGHT)
// bit stream; completed words are handed to a one-entry output buffer.
//   clk, rst     : clock, async active-high reset
//   start_i      : one-cycle frame marker (bits follow on later cycles)
//   dir_i        : shift direction, sampled with start_i
//   bit_valid_i  : serial_i carries a valid bit this cycle
//   serial_i     : serial data bit
//   ready_i      : consumer accepts word_o this cycle
//   word_o       : assembled word
//   valid_o      : word_o holds an unconsumed word
//   busy_o       : frame in progress
//   overrun_o    : one-cycle pulse, completed word dropped
//   error_o      : one-cycle pulse, start_i with illegal dir_i
module serial_word_receiver
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  funct_t           dir_i,
  input  logic             bit_valid_i,
  input  logic             serial_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             error_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  funct_t           dir_q, dir_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] sreg_next_c;
  logic             complete_c;

  // Shift register with the current bit inserted according to the frame direction.
  always_comb begin
    if (dir_q == LEFT) sreg_next_c = {sreg_q[WIDTH-2:0], serial_i};
    else               sreg_next_c = {serial_i, sreg_q[WIDTH-1:1]};
  end

  // Next-state: start_i has priority over any bit arriving in the same cycle.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    error_d    = 1'b0;
    complete_c = 1'b0;
    if (start_i) begin
      sreg_d = '0;
      cnt_d  = '0;
      if (is_shift_dir(dir_i)) begin
        dir_d   = dir_i;
        state_d = SHIFT;
      end else begin
        error_d = 1'b1;
        state_d = IDLE;
      end
    end else if (state_q == SHIFT && bit_valid_i) begin
      sreg_d = sreg_next_c;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        complete_c = 1'b1;
        cnt_d      = '0;
        state_d    = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= NA;
      sreg_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  word_out_buffer #(
    .WIDTH (WIDTH)
  ) u_word_out_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (complete_c),
    .data_i    (sreg_next_c),
    .ready_i   (ready_i),
    .word_o    (word_o),
    .valid_o   (valid_o),
    .overrun_o (overrun_o)
  );

  assign busy_o  = (state_q == SHIFT);
  assign error_o = error_q;

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
Serial-to-parallel receiver: the receiving end of a serial bit stream produced by a shift register that is shifting out LEFT (MSB first) or RIGHT (LSB first).
- Assembles WIDTH bits into a word and presents it on a valid/ready output handshake.
- A one-word output buffer lets the next frame be shifted in while the previous word waits for the consumer.
- Sits between a serial link and any parallel consumer in the datapath.

Parameters:
WIDTH, 4, word width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-high.
- start_i  input  1  one-cycle frame marker; bits follow on later cycles.
- dir_i  input  funct_t (2)  shift direction, sampled only with start_i. LEFT = MSB first, RIGHT = LSB first.
- bit_valid_i  input  1  serial_i carries a valid bit this cycle.
- serial_i  input  1  serial data bit.
- ready_i  input  1  consumer accepts word_o this cycle.
- word_o  output  WIDTH  assembled word (output buffer).
- valid_o  output  1  word_o holds an unconsumed word.
- busy_o  output  1  frame in progress (state SHIFT).
- overrun_o  output  1  one-cycle pulse: completed word dropped.
- error_o  output  1  one-cycle pulse: start_i with illegal dir_i.

Behaviour:
- Reset (async, any state, including mid-frame):
  - state = IDLE; shift reg, bit count and word_o = '0.
  - valid_o, busy_o, overrun_o, error_o = 0.
- FSM states are IDLE and SHIFT.
  - IDLE:
    - start_i with dir_i in {LEFT, RIGHT}: capture dir, clear shift reg and count, go to SHIFT.
    - start_i with dir_i in {NA, LOAD}: error_o = 1 next cycle, stay in IDLE.
    - bit_valid_i without a frame is ignored.
  - SHIFT:
    - On each bit_valid_i, shift the bit in and increment the count.
    - LEFT: sreg_next = {sreg[WIDTH-2:0], serial_i}.
    - RIGHT: sreg_next = {serial_i, sreg[WIDTH-1:1]}.
    - Cycles with bit_valid_i = 0 hold state (gaps allowed, no timeout).
  - Frame completion: bit_valid_i while count == WIDTH-1.
    - The completed word is sreg_next; the FSM returns to IDLE.
    - Latency: word_o and valid_o update on the clock edge that samples the last bit (visible the following cycle).
  - start_i while in SHIFT: current partial frame discarded, new frame begins with the same rules as IDLE. An illegal dir_i gives error_o and a return to IDLE. No overrun.
  - start_i and bit_valid_i in the same cycle: start_i wins; that bit is ignored.
- busy_o = (state == SHIFT).
- Output handshake:
  - A word is transferred when valid_o && ready_i.
  - Once valid_o is high, it and word_o stay stable until the transfer.
  - Transfer without a completion in the same cycle: valid_o = 0 next cycle; word_o keeps its stale value.
  - Completion with valid_o = 0: load word_o, valid_o = 1.
  - Completion with valid_o && ready_i: load the new word, valid_o stays 1 (back-to-back, no bubble).
  - Completion with valid_o && !ready_i: new word dropped, word_o unchanged, overrun_o = 1 for one cycle.
- Count width is $clog2(WIDTH). The count never wraps; it is cleared on start and on completion.
- overrun_o and error_o are registered pulses and never assert in consecutive cycles from the same event.

Decomposition:
- Move funct_t (NA/LOAD/LEFT/RIGHT) into a shared package, shift_pkg. Both this block and the existing shift register import it, so dir_i legality uses the same encoding as the transmitter.
- The state enum (IDLE, SHIFT) is local to the module.
- One natural sub-module: word_out_buffer. It is the one-entry valid/ready holding register with the overrun flag and is reusable elsewhere.
- The rest (FSM, counter, shift reg) stays in the top module.

Test Plan:
- LEFT frame, WIDTH=4: start_i, dir=LEFT, then bits 1,0,1,1 on consecutive cycles, ready_i=1 -> word_o=4'b1011, valid_o high exactly one cycle, one cycle after the last bit.
- RIGHT frame with gaps: dir=RIGHT, bits 1,0,0,1,... sent as 1,(gap),0,0,(gap 3 cycles),1 -> word_o=4'b1001 after the 4th valid bit; busy_o high throughout the gaps.
- Backpressure/overrun: frame A=4'hA completes with ready_i=0, then frame B=4'h5 completes with ready_i still 0 -> word_o stays 4'hA, overrun_o pulses once. Then ready_i=1 -> valid_o drops.
- Back-to-back: frame B completes in the same cycle word A is accepted -> word_o=B, valid_o stays 1, no overrun.
- Restart/illegal: start_i mid-frame after 2 bits, then 4 new bits 0,1,1,0 LEFT -> word_o=4'b0110. A separate start_i with dir=LOAD -> error_o pulse, busy_o stays 0.
- Async reset mid-frame with valid_o=1: rst asserted between clock edges -> all outputs 0 immediately. A later frame decodes correctly from a clean state.
